apb_mtimer: RTL

- Memory-mapped RISC-V machine timer and software-interrupt unit on a spare APB slot of the core-complex APB fabric (32-bit data, 12-bit address decode).
- Produces the core's machine-timer (irq_mti) and machine-software (irq_msi) interrupt inputs.
- Holds a free-running 64-bit mtime with a programmable prescaler, a 64-bit mtimecmp compare register and an msip bit.

---
 rtl/apb_mtimer_pkg.sv | 39 +++
 rtl/apb_mtimer_if.sv | 24 ++
 rtl/apb_mtimer_prescaler.sv | 33 +++
 rtl/apb_mtimer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/apb_mtimer_pkg.sv
// Shared definitions for the APB machine timer: register offsets, CTRL field layout,
// register-select enum and the address decoder used by the top level.
package apb_mtimer_pkg;

  localparam logic [11:0] MTIMER_MTIME_LO_OFS    = 12'h000;
  localparam logic [11:0] MTIMER_MTIME_HI_OFS    = 12'h004;
  localparam logic [11:0] MTIMER_MTIMECMP_LO_OFS = 12'h008;
  localparam logic [11:0] MTIMER_MTIMECMP_HI_OFS = 12'h00C;
  localparam logic [11:0] MTIMER_MSIP_OFS        = 12'h010;
  localparam logic [11:0] MTIMER_CTRL_OFS        = 12'h014;

  // CTRL layout: bit0 enable, prescaler divide field starting at bit 8.
  localparam int unsigned MTIMER_CTRL_EN_BIT    = 0;
  localparam int unsigned MTIMER_CTRL_PRESC_LSB = 8;

  typedef enum logic [2:0] {
    RegMtimeLo,
    RegMtimeHi,
    RegCmpLo,
    RegCmpHi,
    RegMsip,
    RegCtrl,
    RegNone
  } mtimer_reg_e;

  // Decodes a word address (byte address >> 2); anything unmapped yields RegNone.
  function automatic mtimer_reg_e mtimer_decode(logic [29:0] word);
    mtimer_reg_e sel;
    sel = RegNone;
    if (word == 30'(MTIMER_MTIME_LO_OFS >> 2))    sel = RegMtimeLo;
    if (word == 30'(MTIMER_MTIME_HI_OFS >> 2))    sel = RegMtimeHi;
    if (word == 30'(MTIMER_MTIMECMP_LO_OFS >> 2)) sel = RegCmpLo;
    if (word == 30'(MTIMER_MTIMECMP_HI_OFS >> 2)) sel = RegCmpHi;
    if (word == 30'(MTIMER_MSIP_OFS >> 2))        sel = RegMsip;
    if (word == 30'(MTIMER_CTRL_OFS >> 2))        sel = RegCtrl;
    return sel;
  endfunction

endpackage

// File: rtl/apb_mtimer_if.sv
// APB3 bus bundle for the machine timer slot.
// master: drives paddr/pwdata/pwrite/psel/penable; slave: drives prdata/pready/pslverr.
interface apb_mtimer_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [31:0]               pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [31:0]               prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mtimer_prescaler.sv
// Prescaler for mtime: counts enabled cycles and emits a one-cycle tick every presc_i+1 cycles.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i count enable; presc_i divide
// value; clr_i synchronous counter clear; tick_o advance strobe for mtime.
module apb_mtimer_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               clr_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == presc_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/apb_mtimer.sv
// RISC-V machine timer / software interrupt unit on an APB slot.
// Ports: clk_i/rst_ni clock and async active-low reset; apb APB slave bundle (zero wait
// states, pslverr on unmapped offsets); irq_mti_o timer interrupt level; irq_msi_o software
// interrupt level; mtime_o current mtime for trace.
module apb_mtimer
  import apb_mtimer_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned PRESC_W        = 8,
  parameter logic [63:0] MTIME_RST      = 64'h0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  apb_mtimer_if.slave        apb,
  output logic               irq_mti_o,
  output logic               irq_msi_o,
  output logic [63:0]        mtime_o
);

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        cmp_q, cmp_d;
  logic               msip_q, msip_d;
  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               irq_mti_q, irq_msi_q;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [31:0]               addr32;
  logic                      unused_addr;
  mtimer_reg_e               sel;
  logic                      access, wr, rd;
  logic                      tick;

  assign paddr       = apb.paddr;
  assign addr32      = 32'(paddr);
  assign unused_addr = ^addr32[1:0];
  assign sel         = mtimer_decode(addr32[31:2]);
  assign access      = apb.psel && apb.penable;
  assign wr          = access && apb.pwrite;
  assign rd          = access && !apb.pwrite;

  apb_mtimer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_q),
    .presc_i(presc_q),
    .clr_i  (wr && (sel == RegCtrl)),
    .tick_o (tick)
  );

  // Register writes win over the tick: a write to either mtime half suppresses the increment.
  always_comb begin
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    msip_d  = msip_q;
    en_d    = en_q;
    presc_d = presc_q;
    if (wr && (sel == RegMtimeLo)) begin
      mtime_d = {mtime_q[63:32], apb.pwdata};
    end else if (wr && (sel == RegMtimeHi)) begin
      mtime_d = {apb.pwdata, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr) begin
      unique case (sel)
        RegCmpLo: cmp_d   = {cmp_q[63:32], apb.pwdata};
        RegCmpHi: cmp_d   = {apb.pwdata, cmp_q[31:0]};
        RegMsip:  msip_d  = apb.pwdata[0];
        RegCtrl: begin
          en_d    = apb.pwdata[MTIMER_CTRL_EN_BIT];
          presc_d = apb.pwdata[MTIMER_CTRL_PRESC_LSB +: PRESC_W];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q   <= MTIME_RST;
      cmp_q     <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q    <= 1'b0;
      en_q      <= 1'b1;
      presc_q   <= '0;
      irq_mti_q <= 1'b0;
      irq_msi_q <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      msip_q    <= msip_d;
      en_q      <= en_d;
      presc_q   <= presc_d;
      // Compare on post-update values so a cmp write takes effect on the same edge.
      irq_mti_q <= (mtime_d >= cmp_d);
      irq_msi_q <= msip_d;
    end
  end

  always_comb begin
    apb.prdata = '0;
    if (rd) begin
      unique case (sel)
        RegMtimeLo: apb.prdata = mtime_q[31:0];
        RegMtimeHi: apb.prdata = mtime_q[63:32];
        RegCmpLo:   apb.prdata = cmp_q[31:0];
        RegCmpHi:   apb.prdata = cmp_q[63:32];
        RegMsip:    apb.prdata = {31'b0, msip_q};
        RegCtrl: begin
          apb.prdata[MTIMER_CTRL_EN_BIT]                 = en_q;
          apb.prdata[MTIMER_CTRL_PRESC_LSB +: PRESC_W]   = presc_q;
        end
        default:    apb.prdata = '0;
      endcase
    end
  end

  assign apb.pready   = 1'b1;
  assign apb.pslverr  = access && (sel == RegNone);
  assign irq_mti_o    = irq_mti_q;
  assign irq_msi_o    = irq_msi_q;
  assign mtime_o      = mtime_q;

endmodule
